// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the run/pause/clear counter sequencer: state encodings,
// default timing constants and the state transition function.
package counter_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_CLEAR = 2'b11
    } state_t;

    localparam int DEF_CLK_DIV    = 1000;
    localparam int DEF_LONG_PRESS = 2000;
    localparam int DEF_CNT_W      = 4;

    // CLEAR always lasts one cycle and ignores key events arriving during it.
    function automatic state_t next_state(input state_t cur, input logic short_evt,
                                          input logic long_evt);
        state_t nxt;
        nxt = cur;
        unique case (cur)
            ST_IDLE, ST_RUN, ST_PAUSE: begin
                if (long_evt) begin
                    nxt = ST_CLEAR;
                end else if (short_evt) begin
                    nxt = (cur == ST_RUN) ? ST_PAUSE : ST_RUN;
                end
            end
            ST_CLEAR: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/counter_seq_ctrl_key_press_classifier.sv
// Splits a debounced key level into one-cycle short-press and long-press events.
// A key already held when reset is released never produces an event.
module key_press_classifier
    import counter_seq_ctrl_pkg::*;
#(
    parameter int LONG_PRESS = DEF_LONG_PRESS
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_short,
    output logic o_long
);

    localparam int HOLD_W = $clog2(LONG_PRESS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS - 1);

    logic              key_prev_reg;
    logic [HOLD_W-1:0] hold_reg;
    logic              long_fired_reg;
    logic              short_reg;
    logic              long_reg;

    logic press_evt;
    logic rel_evt;

    assign press_evt = i_key & ~key_prev_reg;
    assign rel_evt   = ~i_key & key_prev_reg;

    // long_fired resets to 1 so that releasing a key held through reset is silent;
    // only a fresh press re-arms the classifier.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            key_prev_reg   <= 1'b1;
            hold_reg       <= '0;
            long_fired_reg <= 1'b1;
            short_reg      <= 1'b0;
            long_reg       <= 1'b0;
        end else begin
            key_prev_reg <= i_key;
            short_reg    <= 1'b0;
            long_reg     <= 1'b0;
            if (press_evt) begin
                hold_reg       <= '0;
                long_fired_reg <= 1'b0;
            end else if (i_key) begin
                if (hold_reg != HOLD_MAX) begin
                    hold_reg <= hold_reg + HOLD_W'(1);
                end
                if (hold_reg == HOLD_LAST && !long_fired_reg) begin
                    long_reg       <= 1'b1;
                    long_fired_reg <= 1'b1;
                end
            end else if (rel_evt && !long_fired_reg) begin
                short_reg <= 1'b1;
            end
        end
    end

    assign o_short = short_reg;
    assign o_long  = long_reg;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run/pause/clear sequencer: key events drive the FSM, a prescaler gated by RUN
// issues count ticks, and the count register steps up or down on each tick.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int LONG_PRESS = DEF_LONG_PRESS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_key,
    input  logic             i_dir,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_q,
    output logic             o_wrap,
    output logic             o_running,
    output logic [1:0]       o_state
);

    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic short_evt;
    logic long_evt;

    key_press_classifier #(
        .LONG_PRESS(LONG_PRESS)
    ) u_classifier (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_key  (i_key),
        .o_short(short_evt),
        .o_long (long_evt)
    );

    state_t             state_reg;
    state_t             state_next;
    logic               running_reg;
    logic [PRE_W-1:0]   presc_reg;
    logic [CNT_W-1:0]   q_reg;
    logic [CNT_W-1:0]   q_next;
    logic               wrap_next;
    logic               tick_reg;
    logic               wrap_reg;

    always_comb begin
        state_next = next_state(state_reg, short_evt, long_evt);
        q_next     = i_dir ? (q_reg - CNT_W'(1)) : (q_reg + CNT_W'(1));
        wrap_next  = i_dir ? ~(|q_reg) : (&q_reg);
    end

    // A tick in the same cycle as a key event still updates the count; the
    // state change lands on that same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            running_reg <= 1'b0;
            presc_reg   <= '0;
            q_reg       <= '0;
            tick_reg    <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            running_reg <= (state_next == ST_RUN);
            tick_reg    <= 1'b0;
            wrap_reg    <= 1'b0;
            if (state_reg == ST_CLEAR) begin
                presc_reg <= '0;
                q_reg     <= '0;
            end else if (state_reg == ST_RUN) begin
                if (presc_reg == PRE_LAST) begin
                    presc_reg <= '0;
                    tick_reg  <= 1'b1;
                    q_reg     <= q_next;
                    wrap_reg  <= wrap_next;
                end else begin
                    presc_reg <= presc_reg + PRE_W'(1);
                end
            end
        end
    end

    assign o_tick    = tick_reg;
    assign o_q       = q_reg;
    assign o_wrap    = wrap_reg;
    assign o_running = running_reg;
    assign o_state   = state_reg;

endmodule
